// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of clk_in in sys_clk cycles, with a timeout flag.
// Define DUTY_MEAS_EN to build the high-time counter; otherwise high_time is tied to 0.
module clk_period_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_timeout;
    logic             w_rise;
`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_high;
    assign high_time = r_high;
`else
    assign high_time = '0;
`endif
    assign w_rise     = r_s2 & ~r_s3;
    assign period     = r_period;
    assign meas_valid = r_valid;
    assign timeout    = r_timeout;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {r_s1, r_s2, r_s3} <= '0;
            r_state            <= IDLE;
            r_cnt              <= '0;
            r_period           <= '0;
            r_valid            <= 1'b0;
            r_timeout          <= 1'b0;
`ifdef DUTY_MEAS_EN
            r_hcnt             <= '0;
            r_high             <= '0;
`endif
        end else begin
            {r_s1, r_s2, r_s3} <= {clk_in, r_s1, r_s2};
            r_valid            <= 1'b0;
            if (!meas_en) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_timeout <= 1'b0;
`ifdef DUTY_MEAS_EN
                r_hcnt    <= '0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ARM;
                        r_cnt   <= '0;
                    end
                    ARM: begin
                        if (w_rise) begin
                            r_state <= MEAS;
                            r_cnt   <= CNT_W'(1);
`ifdef DUTY_MEAS_EN
                            r_hcnt  <= CNT_W'(1);
`endif
                        end else if (r_cnt == TO) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    MEAS: begin
                        // rise outranks a coincident timeout so a period of exactly TIMEOUT is still published
                        if (w_rise) begin
                            r_period  <= r_cnt;
                            r_valid   <= 1'b1;
                            r_timeout <= 1'b0;
                            r_cnt     <= CNT_W'(1);
`ifdef DUTY_MEAS_EN
                            r_high    <= r_hcnt;
                            r_hcnt    <= CNT_W'(1);
`endif
                        end else if (r_cnt == TO) begin
                            r_timeout <= 1'b1;
                            r_state   <= ARM;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt  <= r_cnt + CNT_W'(1);
`ifdef DUTY_MEAS_EN
                            r_hcnt <= r_hcnt + CNT_W'(r_s2);
`endif
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
